// File: rtl/challenge_obfuscator_tn_pkg.sv
// Shared types and helpers for the challenge obfuscator and future multi-PUF wrappers.
package challenge_obfuscator_tn_pkg;

  // Enrollment FSM: hold cells in clear, collect votes, then serve challenges.
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  // Widest challenge/vote vector the mapping helper handles.
  localparam int MAP_MAX_W = 64;

  // Spread NPUF votes across a cw-bit mask. Bit i uses cell k = i % npuf.
  // Even groups (i / npuf) take the vote directly; odd groups XOR it with
  // the neighbouring cell's vote so repeated groups are not plain copies.
  function automatic logic [MAP_MAX_W-1:0] mask_map(input logic [MAP_MAX_W-1:0] vote,
                                                    input int cw,
                                                    input int npuf);
    logic [MAP_MAX_W-1:0] m;
    int k;
    int g;
    m = '0;
    for (int i = 0; i < MAP_MAX_W; i++) begin
      if (i < cw) begin
        k = i % npuf;
        g = i / npuf;
        if ((g % 2) == 0) m[i] = vote[k];
        else              m[i] = vote[k] ^ vote[(k + 1) % npuf];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/challenge_obfuscator_tn_if.sv
// Challenge in / obfuscated challenge out stream bundle.
// Handshake: a word moves when valid & ready are both 1 at a rising edge;
// the producer holds valid and data stable until that edge, and ready may
// depend combinationally on downstream ready but never on valid.
interface challenge_obfuscator_tn_if #(
  parameter int CW = 8
);
  logic          c_valid;
  logic          c_ready;
  logic [CW-1:0] c;
  logic          cb_valid;
  logic          cb_ready;
  logic [CW-1:0] c_bar;

  modport master (
    output c_valid, c, cb_ready,
    input  c_ready, cb_valid, c_bar
  );

  modport slave (
    input  c_valid, c, cb_ready,
    output c_ready, cb_valid, c_bar
  );
endinterface

// File: rtl/challenge_obfuscator_tn_vote_counter.sv
// puf_vote_counter: per-cell saturating ones counter with majority and
// unanimity decode.
module puf_vote_counter #(
  parameter int VOTES = 7
) (
  input  logic clk,
  input  logic clear,
  input  logic cnt_clr,
  input  logic cnt_en,
  input  logic resp,
  output logic vote,
  output logic unstable
);
  localparam int CNT_W = $clog2(VOTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VOTES);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(VOTES / 2 + 1);

  logic [CNT_W-1:0] cnt;

  // Count ones while sampling; stick at VOTES instead of wrapping.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                                cnt <= '0;
    else if (cnt_clr)                          cnt <= '0;
    else if (cnt_en && resp && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  assign vote     = (cnt >= CNT_THR);
  assign unstable = (cnt != '0) && (cnt != CNT_MAX);
endmodule

// File: rtl/pico_puf.sv
// Behavioural stand-in for the existing pico_puf cell: responds with a fixed
// bias bit after clear is released. Real silicon replaces this module.
module pico_puf #(
  parameter bit BIAS = 1'b0
) (
  input  logic clk,
  input  logic clear,
  output logic resp
);
  // Response register, forced low while the cell is held in clear.
  always_ff @(posedge clk) begin
    resp <= clear ? 1'b0 : BIAS;
  end
endmodule

// File: rtl/challenge_obfuscator_tn.sv
// Challenge obfuscator: enrolls NPUF pico_puf cells by majority vote, builds
// a CW-bit mask from the votes and XORs it onto a registered challenge stream.
module challenge_obfuscator_tn
  import challenge_obfuscator_tn_pkg::*;
#(
  parameter int CW     = 8,
  parameter int NPUF   = 4,
  parameter int VOTES  = 7,
  parameter int SETTLE = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    regen,
  challenge_obfuscator_tn_if.slave s,
  output logic                    mask_valid,
  output logic [NPUF-1:0]         unstable,
  output state_e                  dbg_state
);
  localparam int PH_MAX = (SETTLE > VOTES) ? SETTLE : VOTES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            puf_clr;
  logic            cnt_clr;
  logic            cnt_en;
  logic            mask_load;
  logic [NPUF-1:0] puf_resp;
  logic [NPUF-1:0] vote;
  logic [NPUF-1:0] unstable_w;
  logic [NPUF-1:0] unstable_q;
  logic [CW-1:0]   mask_q;
  logic            mask_valid_q;
  logic [CW-1:0]   c_bar_q;
  logic            cb_valid_q;
  logic            c_ready;
  logic            accept;

  // One PUF cell plus its vote counter per lane.
  for (genvar k = 0; k < NPUF; k++) begin : g_cell
    (* dont_touch = "true" *)
    pico_puf #(.BIAS((k % 2) == 0)) u_puf (
      .clk   (clk),
      .clear (puf_clr),
      .resp  (puf_resp[k])
    );

    puf_vote_counter #(.VOTES(VOTES)) u_cnt (
      .clk      (clk),
      .clear    (clear),
      .cnt_clr  (cnt_clr),
      .cnt_en   (cnt_en),
      .resp     (puf_resp[k]),
      .vote     (vote[k]),
      .unstable (unstable_w[k])
    );
  end

  // FSM state and phase counter registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_SETTLE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Next state and control strobes; regen overrides everything and restarts.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    puf_clr   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    mask_load = 1'b0;
    unique case (state_q)
      ST_SETTLE: begin
        puf_clr = 1'b1;
        cnt_clr = 1'b1;
        if (ph_q == PH_W'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_SAMPLE: begin
        cnt_en = 1'b1;
        if (ph_q == PH_W'(VOTES - 1)) begin
          state_d = ST_READY;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_READY: begin
        mask_load = !mask_valid_q;
      end
      default: begin
        state_d = ST_SETTLE;
        ph_d    = '0;
      end
    endcase
    if (regen) begin
      state_d   = ST_SETTLE;
      ph_d      = '0;
      cnt_clr   = 1'b1;
      cnt_en    = 1'b0;
      mask_load = 1'b0;
    end
  end

  // Mask register: latched once per enrollment, discarded on regen.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      unstable_q   <= '0;
    end else if (regen) begin
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
    end else if (mask_load) begin
      mask_q       <= CW'(mask_map({{(MAP_MAX_W - NPUF){1'b0}}, vote}, CW, NPUF));
      mask_valid_q <= 1'b1;
      unstable_q   <= unstable_w;
    end
  end

  assign c_ready = mask_valid_q & (~cb_valid_q | s.cb_ready);
  assign accept  = s.c_valid & c_ready;

  // One-deep output register; a word accepted with regen uses the old mask.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      c_bar_q    <= '0;
      cb_valid_q <= 1'b0;
    end else if (accept) begin
      c_bar_q    <= s.c ^ mask_q;
      cb_valid_q <= 1'b1;
    end else if (s.cb_ready) begin
      cb_valid_q <= 1'b0;
    end
  end

  assign s.c_ready  = c_ready;
  assign s.cb_valid = cb_valid_q;
  assign s.c_bar    = c_bar_q;
  assign mask_valid = mask_valid_q;
  assign unstable   = unstable_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_challenge_obfuscator_tn.sv
// Bench for challenge_obfuscator_tn: forced PUF responses, reference model of
// enrollment timing, voting and the one-word output stage.
module tb_challenge_obfuscator_tn;
  import challenge_obfuscator_tn_pkg::*;

  localparam int CW     = 8;
  localparam int NPUF   = 4;
  localparam int VOTES  = 7;
  localparam int SETTLE = 4;
  localparam int THR    = VOTES / 2 + 1;

  logic            clk;
  logic            clear;
  logic            regen;
  logic            mask_valid;
  logic [NPUF-1:0] unstable;
  state_e          dbg_state;

  challenge_obfuscator_tn_if #(.CW(CW)) bus();

  challenge_obfuscator_tn #(
    .CW(CW), .NPUF(NPUF), .VOTES(VOTES), .SETTLE(SETTLE)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .regen      (regen),
    .s          (bus),
    .mask_valid (mask_valid),
    .unstable   (unstable),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [CW-1:0]   exp_q[$];
  bit              mv_m;
  logic [CW-1:0]   mask_m;
  logic [NPUF-1:0] unst_m;
  int              ones_m[NPUF];
  int              since_start;
  logic [NPUF-1:0] resp_d;
  int              n_checks;
  int              n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mask from votes: bit i reads cell i%NPUF; odd groups XOR in the next cell.
  function automatic logic [CW-1:0] ref_mask(input logic [NPUF-1:0] v);
    logic [CW-1:0] m;
    for (int i = 0; i < CW; i++) begin
      if (((i / NPUF) % 2) == 0) m[i] = v[i % NPUF];
      else                       m[i] = v[i % NPUF] ^ v[(i % NPUF + 1) % NPUF];
    end
    return m;
  endfunction

  function automatic bit in_win(input int e);
    return (e >= SETTLE) && (e < SETTLE + VOTES);
  endfunction

  task automatic model_restart();
    mv_m        = 1'b0;
    since_start = 0;
    for (int k = 0; k < NPUF; k++) ones_m[k] = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mask_m = '0;
    unst_m = '0;
    model_restart();
  endtask

  task automatic set_resp(input logic [NPUF-1:0] v);
    resp_d = v;
    force dut.puf_resp = resp_d;
  endtask

  // Called at posedge+1 with inputs applied; checks, advances model, crosses one edge.
  task automatic cycle();
    logic            exp_ready;
    logic [NPUF-1:0] v;
    bit              acc;
    #1;
    exp_ready = mv_m && (exp_q.size() == 0 || bus.cb_ready);
    check("mask_valid", mask_valid, mv_m);
    check("c_ready", bus.c_ready, exp_ready);
    check("cb_valid", bus.cb_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("c_bar", bus.c_bar, exp_q[0]);
    check("unstable", unstable, unst_m);
    if (mv_m) check("state_ready", dbg_state, ST_READY);
    acc = bus.c_valid && exp_ready;
    if (exp_q.size() != 0 && bus.cb_ready) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(bus.c ^ mask_m);
    if (regen) begin
      model_restart();
    end else if (!mv_m) begin
      since_start++;
      if (since_start > SETTLE && since_start <= SETTLE + VOTES) begin
        for (int k = 0; k < NPUF; k++) ones_m[k] += int'(resp_d[k]);
      end else if (since_start == SETTLE + VOTES + 1) begin
        for (int k = 0; k < NPUF; k++) begin
          v[k]      = (ones_m[k] >= THR);
          unst_m[k] = (ones_m[k] != 0) && (ones_m[k] != VOTES);
        end
        mask_m = ref_mask(v);
        mv_m   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit cv, input logic [CW-1:0] cval, input bit cbr,
                      input bit rg, input logic [NPUF-1:0] rsp);
    bus.c_valid  = cv;
    bus.c        = cval;
    bus.cb_ready = cbr;
    regen        = rg;
    set_resp(rsp);
    cycle();
  endtask

  bit c0_seq[VOTES] = '{1, 1, 0, 1, 0, 1, 1};
  bit c1_seq[VOTES] = '{0, 1, 0, 1, 0, 1, 0};

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear        = 1'b0;
    regen        = 1'b0;
    bus.c_valid  = 1'b0;
    bus.c        = '0;
    bus.cb_ready = 1'b0;
    set_resp('0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_mask_valid", mask_valid, 1'b0);
    check("rst_c_ready", bus.c_ready, 1'b0);
    check("rst_cb_valid", bus.cb_valid, 1'b0);
    check("rst_c_bar", bus.c_bar, '0);
    check("rst_unstable", unstable, '0);
    check("rst_state", dbg_state, ST_SETTLE);

    // enrollment with constant cells 1,0,1,1; mask_valid after exactly 12 edges
    clear = 1'b1;
    model_reset();
    for (int e = 0; e < SETTLE + VOTES + 2; e++)
      step(0, CW'($urandom), 1, 0, in_win(e) ? 4'b1101 : NPUF'($urandom));
    check("const_unstable", unstable, 4'b0000);
    check("const_mask_valid", mask_valid, 1'b1);

    // back-to-back FF then 00, full throughput
    step(1, 8'hFF, 1, 0, NPUF'($urandom));
    step(1, 8'h00, 1, 0, NPUF'($urandom));
    step(0, CW'($urandom), 1, 0, NPUF'($urandom));
    step(0, CW'($urandom), 1, 0, NPUF'($urandom));

    // stall: word held while cb_ready=0, drained and refilled in one cycle
    step(1, CW'($urandom), 0, 0, NPUF'($urandom));
    repeat (3) step(1, 8'hA5, 0, 0, NPUF'($urandom));
    step(1, 8'hA5, 1, 0, NPUF'($urandom));
    step(0, CW'($urandom), 1, 0, NPUF'($urandom));

    // re-enroll with mixed vote patterns
    step(0, CW'($urandom), 1, 1, NPUF'($urandom));
    for (int e = 0; e < SETTLE + VOTES + 1; e++)
      step($urandom_range(0, 1), CW'($urandom), 1, 0,
           in_win(e) ? {1'b0, 1'b1, c1_seq[e - SETTLE], c0_seq[e - SETTLE]}
                     : NPUF'($urandom));
    step(0, CW'($urandom), 1, 0, NPUF'($urandom));
    check("mixed_unstable", unstable, 4'b0011);
    repeat (4) step(1, CW'($urandom), 1, 0, NPUF'($urandom));

    // regen with a pending word and downstream stalled
    step(1, CW'($urandom), 0, 0, NPUF'($urandom));
    step(1, CW'($urandom), 0, 1, NPUF'($urandom));
    repeat (3) step($urandom_range(0, 1), CW'($urandom), 0, 0, NPUF'($urandom));
    for (int e = 0; e < SETTLE + VOTES + 2; e++)
      step($urandom_range(0, 1), CW'($urandom), 1, 0, NPUF'($urandom));

    // asynchronous clear in the middle of sampling
    step(1, CW'($urandom), 0, 0, NPUF'($urandom));
    step(0, CW'($urandom), 0, 1, NPUF'($urandom));
    repeat (SETTLE + 3) step(0, CW'($urandom), 0, 0, NPUF'($urandom));
    #2;
    clear = 1'b0;
    #1;
    check("aclr_mask_valid", mask_valid, 1'b0);
    check("aclr_c_ready", bus.c_ready, 1'b0);
    check("aclr_cb_valid", bus.cb_valid, 1'b0);
    check("aclr_c_bar", bus.c_bar, '0);
    check("aclr_unstable", unstable, '0);
    check("aclr_state", dbg_state, ST_SETTLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    clear = 1'b1;
    model_reset();
    for (int e = 0; e < SETTLE + VOTES + 2; e++)
      step($urandom_range(0, 1), CW'($urandom), 1, 0, NPUF'($urandom));

    // random traffic with occasional regen
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, NPUF'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
